lsu_ctrl: RTL and testbench

- Load/store initiator that drives the byte-addressed data memory port: daddr, dwdata, we code; reads back drdata.
- Accepts one load or store per request from the CPU datapath over a valid/ready handshake.
- Encodes the byte-lane write code, replicates store data onto lanes, and extracts/extends load data.
- Flags misaligned accesses without touching memory.

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_align.sv | 53 +++++
 rtl/lsu_ctrl.sv | 122 ++++++++++++
 tb/tb_lsu_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, memory write codes
// and the controller state type.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [3:0] WE_NONE = 4'd0;
  localparam logic [3:0] WE_B0   = 4'd1;
  localparam logic [3:0] WE_B1   = 4'd2;
  localparam logic [3:0] WE_B2   = 4'd3;
  localparam logic [3:0] WE_B3   = 4'd4;
  localparam logic [3:0] WE_HLO  = 4'd5;
  localparam logic [3:0] WE_HHI  = 4'd7;
  localparam logic [3:0] WE_WORD = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  // Size 3 is illegal; it reports 4 bytes so the range check stays well defined.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: write code, store-data replication, load
// extraction/extension and alignment check for one access.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] drdata,
  output logic [3:0]  we_code,
  output logic [31:0] dwdata,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0] rd_lane [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_lane[gi] = drdata[8*gi +: 8];
  end

  logic [15:0] rd_half;

  always_comb begin
    we_code   = WE_NONE;
    dwdata    = wdata;
    rdata_ext = drdata;
    misalign  = 1'b0;
    rd_half   = off[1] ? drdata[31:16] : drdata[15:0];
    case (size)
      SZ_BYTE: begin
        we_code   = WE_B0 + {2'b00, off};
        dwdata    = {4{wdata[7:0]}};
        rdata_ext = {{24{~is_unsigned & rd_lane[off][7]}}, rd_lane[off]};
      end
      SZ_HALF: begin
        misalign  = off[0];
        we_code   = off[0] ? WE_NONE : (off[1] ? WE_HHI : WE_HLO);
        dwdata    = {2{wdata[15:0]}};
        rdata_ext = {{16{~is_unsigned & rd_half[15]}}, rd_half};
      end
      SZ_WORD: begin
        misalign = (off != 2'd0);
        we_code  = (off != 2'd0) ? WE_NONE : WE_WORD;
      end
      default: begin
        misalign = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator: accepts one CPU request, performs a single memory
// access cycle and returns a one-cycle response three cycles per request.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [31:0]       daddr,
  output logic [31:0]       dwdata,
  output logic [3:0]        we,
  input  logic [31:0]       drdata
);

  localparam int AW1 = ADDR_W + 1;

  state_e            state_q, state_d;
  logic              store_q, store_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [3:0]  we_code;
  logic [31:0] rdata_ext;
  logic        misalign;
  logic [AW1-1:0] end_addr;
  logic        out_of_range;
  logic        acc_err;

  lsu_align u_align (
    .size        (size_q),
    .is_unsigned (uns_q),
    .off         (addr_q[1:0]),
    .wdata       (wdata_q),
    .drdata      (drdata),
    .we_code     (we_code),
    .dwdata      (dwdata),
    .rdata_ext   (rdata_ext),
    .misalign    (misalign)
  );

  // One extra bit so addresses near the top of the space cannot wrap past the check.
  assign end_addr     = {1'b0, addr_q} + AW1'(size_bytes(size_q));
  assign out_of_range = end_addr > AW1'(MEM_BYTES);
  assign acc_err      = misalign | out_of_range;

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign daddr      = 32'(addr_q);
  // Reset gates the strobe directly so a store caught mid-access never lands.
  assign we = (state_q == ST_ACCESS && store_q && !acc_err && !reset) ? we_code : WE_NONE;

  always_comb begin
    state_d = state_q;
    store_d = store_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          store_d = req_store;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        err_d   = acc_err;
        rdata_d = (!store_q && !acc_err) ? rdata_ext : 32'h0;
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      store_q <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: byte-array memory, a transaction-level
// reference model and a per-cycle compare process.
module tb_lsu_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req_valid, req_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata, daddr, dwdata, drdata;
  logic [3:0]  we;

  lsu_ctrl #(.ADDR_W(32), .MEM_BYTES(128)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .daddr(daddr), .dwdata(dwdata), .we(we), .drdata(drdata)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc = -100;
  logic chk_en   = 1'b0;
  logic mem_init = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: combinational read of the word containing daddr, write by code.
  logic [7:0] mem     [128];
  logic [7:0] ref_mem [128];
  logic [6:0] wbase;
  assign wbase  = {daddr[6:2], 2'b00};
  assign drdata = {mem[wbase + 7'd3], mem[wbase + 7'd2], mem[wbase + 7'd1], mem[wbase]};

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'(i) ^ 8'h5A;
    end else begin
      case (we)
        4'd1: mem[wbase]         <= dwdata[7:0];
        4'd2: mem[wbase + 7'd1]  <= dwdata[15:8];
        4'd3: mem[wbase + 7'd2]  <= dwdata[23:16];
        4'd4: mem[wbase + 7'd3]  <= dwdata[31:24];
        4'd5: begin
          mem[wbase]        <= dwdata[7:0];
          mem[wbase + 7'd1] <= dwdata[15:8];
        end
        4'd7: begin
          mem[wbase + 7'd2] <= dwdata[23:16];
          mem[wbase + 7'd3] <= dwdata[31:24];
        end
        4'd8: begin
          mem[wbase]        <= dwdata[7:0];
          mem[wbase + 7'd1] <= dwdata[15:8];
          mem[wbase + 7'd2] <= dwdata[23:16];
          mem[wbase + 7'd3] <= dwdata[31:24];
        end
        default: ;
      endcase
    end
  end

  typedef struct {
    int          acc;
    logic        abort;
    logic        store;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] dw;
    logic        err;
    logic [31:0] rdata;
  } txn_t;

  txn_t exp_q[$];
  txn_t cur;
  logic [31:0] last_rdata, last_dw;
  logic [3:0]  last_we;
  logic        last_err;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference model: derives the response straight from size/offset rules
  // over a byte-array image of memory.
  task automatic model_issue(input logic st, input logic [1:0] sz, input logic un,
                             input logic [31:0] a, input logic [31:0] wd, input logic abort);
    txn_t t;
    int nb;
    logic [31:0] v;
    nb = 1 << sz;
    t.acc   = cyc;
    t.abort = abort;
    t.store = st;
    t.addr  = a;
    t.err   = (sz == 2'd3) || (a % nb != 0) || ((64'(a) + 64'(nb)) > 64'd128);
    t.we    = 4'd0;
    t.dw    = (sz == 2'd0) ? {4{wd[7:0]}} : (sz == 2'd1) ? {2{wd[15:0]}} : wd;
    t.rdata = 32'h0;
    if (!t.err && !abort) begin
      if (st) begin
        t.we = (sz == 2'd0) ? 4'(1 + a % 4) : (sz == 2'd1) ? ((a % 4 == 0) ? 4'd5 : 4'd7) : 4'd8;
        for (int i = 0; i < nb; i++) ref_mem[7'(a + i)] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[7'(a + i)]) << (8 * i));
        if (!un && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
        t.rdata = v;
      end
    end
    exp_q.push_back(t);
    last_acc = abort ? cyc - 1 : cyc;
  endtask

  task automatic idle_checks();
    check("idle_ready", 32'(req_ready), 32'd1);
    check("idle_resp_valid", 32'(resp_valid), 32'd0);
    check("idle_we", 32'(we), 32'd0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() > 0 && cyc == exp_q[0].acc) begin
        check("acc_ready", 32'(req_ready), 32'd0);
        check("acc_resp_valid", 32'(resp_valid), 32'd0);
        check("acc_we", 32'(we), 32'(exp_q[0].we));
        if (!exp_q[0].abort) begin
          check("acc_daddr", daddr, exp_q[0].addr);
          check("acc_dwdata", dwdata, exp_q[0].dw);
        end
        last_we = we;
        last_dw = dwdata;
      end else if (exp_q.size() > 0 && cyc == exp_q[0].acc + 1) begin
        cur = exp_q.pop_front();
        if (cur.abort) begin
          idle_checks();
          $display("txn aborted addr=%h", cur.addr);
        end else begin
          check("resp_ready", 32'(req_ready), 32'd0);
          check("resp_valid", 32'(resp_valid), 32'd1);
          check("resp_err", 32'(resp_err), 32'(cur.err));
          check("resp_rdata", resp_rdata, cur.rdata);
          check("resp_we", 32'(we), 32'd0);
          last_rdata = resp_rdata;
          last_err   = resp_err;
          $display("txn acc=%0d %s addr=%h err=%0d rdata=%h", cur.acc,
                   cur.store ? "store" : "load", cur.addr, resp_err, resp_rdata);
        end
      end else begin
        idle_checks();
      end
    end
  end

  task automatic do_req(input logic st, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] wd);
    int guard;
    guard = 0;
    @(negedge clk);
    while (cyc + 1 < last_acc + 3 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_store = st; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    model_issue(st, sz, un, a, wd, 1'b0);
    req_valid    = 1'b0;
    req_store    = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  int   diffs;
  logic [9:0] acc_mask;

  initial begin
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    reset = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_daddr", daddr, 32'd0);
    check("rst_dwdata", dwdata, 32'd0);
    check("rst_we", 32'(we), 32'd0);
    reset = 1'b0; mem_init = 1'b0; chk_en = 1'b1;

    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    check("sw10_we", 32'(last_we), 32'd8);
    check("sw10_err", 32'(last_err), 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    check("lw10", last_rdata, 32'hDEADBEEF);

    do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000A5);
    check("sb13_we", 32'(last_we), 32'd4);
    check("sb13_dw", last_dw, 32'hA5A5A5A5);
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    check("lb13", last_rdata, 32'hFFFFFFA5);
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    check("lbu13", last_rdata, 32'h000000A5);

    do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h00008001);
    check("sh22_we", 32'(last_we), 32'd7);
    check("sh22_dw", last_dw, 32'h80018001);
    do_req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
    check("lh22", last_rdata, 32'hFFFF8001);
    do_req(1'b0, 2'd1, 1'b1, 32'h20, 32'h0);
    check("lhu20", last_rdata, 32'h00007B7A);

    do_req(1'b0, 2'd2, 1'b0, 32'h11, 32'h0);
    check("lw11_err", 32'(last_err), 32'd1);
    do_req(1'b1, 2'd1, 1'b0, 32'h23, 32'h1234);
    check("sh23_err", 32'(last_err), 32'd1);
    check("sh23_we", 32'(last_we), 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h7C, 32'h0);
    check("lw7c", last_rdata, 32'h25242726);
    check("lw7c_err", 32'(last_err), 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h80, 32'h0);
    check("lw80_err", 32'(last_err), 32'd1);

    // Remaining lane codes, size 3, and the top-of-memory boundary.
    do_req(1'b0, 2'd3, 1'b0, 32'h00, 32'h0);
    do_req(1'b1, 2'd3, 1'b0, 32'h04, 32'h55667788);
    do_req(1'b1, 2'd0, 1'b0, 32'h31, 32'h0000007E);
    do_req(1'b1, 2'd0, 1'b0, 32'h32, 32'h000000C3);
    do_req(1'b1, 2'd0, 1'b0, 32'h30, 32'hFFFFFF81);
    do_req(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
    do_req(1'b1, 2'd1, 1'b0, 32'h34, 32'hABCD9F00);
    do_req(1'b0, 2'd1, 1'b0, 32'h34, 32'h0);
    do_req(1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
    do_req(1'b1, 2'd0, 1'b0, 32'h7F, 32'h0000003C);
    do_req(1'b1, 2'd1, 1'b0, 32'h7E, 32'h0000BEEF);
    do_req(1'b1, 2'd1, 1'b0, 32'h7F, 32'h00001111);
    do_req(1'b0, 2'd2, 1'b1, 32'h7C, 32'h0);
    do_req(1'b0, 2'd0, 1'b0, 32'h80, 32'h0);

    // Reset during the access cycle of a word store.
    @(negedge clk);
    req_store = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h11223344; req_valid = 1'b1;
    @(posedge clk); #1;
    model_issue(1'b1, 2'd2, 1'b0, 32'h40, 32'h11223344, 1'b1);
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("rst_mem40", {mem[67], mem[66], mem[65], mem[64]}, 32'h19181B1A);
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    check("lw40", last_rdata, 32'h19181B1A);

    // req_valid held for ten edges: accepts only every third edge.
    acc_mask = 10'd0;
    @(negedge clk);
    req_store = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0; req_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (cyc >= last_acc + 3) begin
        model_issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
        acc_mask[k] = 1'b1;
      end
    end
    req_valid = 1'b0;
    check("hs_accepts", 32'(acc_mask), 32'h249);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("hs_drained", 32'(exp_q.size()), 32'd0);

    diffs = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check("mem_final", 32'(diffs), 32'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
